// File: rtl/apb_pkg.sv
// Shared definitions for the parametrised APB3 RAM slave: FSM states,
// response codes and a constant-evaluable clog2 helper.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/apb_ram_slave_ws_if.sv
// APB3 bus bundle between the bridge/decoder (master) and one RAM slave.
interface apb_ram_slave_ws_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_array.sv
// Byte-lane RAM: one 8-bit array per lane so each lane maps onto its own
// block RAM column with an independent write enable. The read port is
// registered and doubles as the slave's PRDATA holding register.
module apb_ram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                rd_en,
  input  logic                rd_clr,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
);
  localparam int STRB_W = DATA_W / 8;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_lane_reg;

      // Lane write: only lanes whose strobe is set are touched.
      always_ff @(posedge clk) begin
        if (wr_en && wr_strb[gi]) begin
          lane_mem[wr_idx] <= wr_data[8*gi +: 8];
        end
      end

      // Registered read; cleared by reset or by an erroring read.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_lane_reg <= '0;
        end else if (rd_clr) begin
          rd_lane_reg <= '0;
        end else if (rd_en) begin
          rd_lane_reg <= lane_mem[rd_idx];
        end
      end

      assign rd_data[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

endmodule

// File: rtl/apb_ram_slave_ws.sv
// APB3 RAM slave with configurable wait states, byte strobes and PSLVERR
// on misaligned or out-of-range addresses. Decode and read happen at the
// SETUP edge; writes commit at the completion edge of the ACCESS phase.
module apb_ram_slave_ws
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  apb_ram_slave_ws_if.slave   bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = clog2(STRB_W);
  localparam int IDX_W  = clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(MEM_DEPTH);

  apb_state_t        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic              write_reg, write_next;

  logic [ADDR_W-1:0] word_addr;
  logic              dec_err;
  logic [IDX_W-1:0]  dec_index;
  logic              rd_en, rd_clr, wr_commit;

  // Address decode of the live bus address, used only at the SETUP edge.
  always_comb begin
    word_addr = bus.paddr >> LSB;
    dec_err   = ((bus.paddr & ALIGN_MASK) != '0) || (word_addr >= DEPTH_A);
    dec_index = bus.paddr[LSB +: IDX_W];
  end

  // State, wait counter and latched transfer attributes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= APB_OKAY;
      index_reg <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      index_reg <= index_next;
      write_reg <= write_next;
    end
  end

  // Next-state logic: SETUP capture, wait countdown, completion, abort.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    index_next = index_reg;
    write_next = write_reg;
    rd_en      = 1'b0;
    rd_clr     = 1'b0;
    wr_commit  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_next = ACCESS;
          cnt_next   = 4'(WAIT_STATES);
          err_next   = dec_err ? APB_ERR : APB_OKAY;
          index_next = dec_index;
          write_next = bus.pwrite;
          rd_en      = !bus.pwrite && !dec_err;
          rd_clr     = !bus.pwrite && dec_err;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          // Master abandoned the transfer: drop it without writing.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (bus.penable) begin
          if (cnt_reg != 4'd0) begin
            cnt_next = cnt_reg - 4'd1;
          end else begin
            state_next = IDLE;
            wr_commit  = write_reg && (err_reg == APB_OKAY);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.pready  = (state_reg == ACCESS) && (cnt_reg == 4'd0);
  assign bus.pslverr = (err_reg == APB_ERR) && bus.pready;

  // A reset landing on the completion edge must not commit the write.
  apb_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_commit && rst_n),
    .wr_idx  (index_reg),
    .wr_data (bus.pwdata),
    .wr_strb (bus.pstrb),
    .rd_en   (rd_en),
    .rd_clr  (rd_clr),
    .rd_idx  (dec_index),
    .rd_data (bus.prdata)
  );

endmodule

// File: tb/tb_apb_ram_slave_ws.sv
// Bench for apb_ram_slave_ws: dut0 has one wait state, dut1 has none.
// The driver pushes the expected response of each transfer into a per-DUT
// queue; a negedge monitor pops and compares whenever a transfer completes.
module tb_apb_ram_slave_ws;
  localparam int WS0 = 1;
  localparam int WS1 = 0;

  typedef struct {
    bit          wr;
    logic [31:0] rd;
    bit          err;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        psel_d    [2];
  logic        penable_d [2];
  logic        pwrite_d  [2];
  logic [31:0] paddr_d   [2];
  logic [31:0] pwdata_d  [2];
  logic [3:0]  pstrb_d   [2];
  logic [31:0] prdata_m  [2];
  logic        pready_m  [2];
  logic        pslverr_m [2];

  exp_t q0[$];
  exp_t q1[$];
  int   acc_cnt [2];
  int   n_pass;
  int   n_total;

  apb_ram_slave_ws_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  apb_ram_slave_ws_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  assign bus0.psel    = psel_d[0];
  assign bus0.penable = penable_d[0];
  assign bus0.pwrite  = pwrite_d[0];
  assign bus0.paddr   = paddr_d[0];
  assign bus0.pwdata  = pwdata_d[0];
  assign bus0.pstrb   = pstrb_d[0];
  assign prdata_m[0]  = bus0.prdata;
  assign pready_m[0]  = bus0.pready;
  assign pslverr_m[0] = bus0.pslverr;

  assign bus1.psel    = psel_d[1];
  assign bus1.penable = penable_d[1];
  assign bus1.pwrite  = pwrite_d[1];
  assign bus1.paddr   = paddr_d[1];
  assign bus1.pwdata  = pwdata_d[1];
  assign bus1.pstrb   = pstrb_d[1];
  assign prdata_m[1]  = bus1.prdata;
  assign pready_m[1]  = bus1.pready;
  assign pslverr_m[1] = bus1.pslverr;

  apb_ram_slave_ws #(
    .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024), .WAIT_STATES(WS0)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  apb_ram_slave_ws #(
    .DATA_W(32), .ADDR_W(32), .MEM_DEPTH(1024), .WAIT_STATES(WS1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: one response check per completed transfer.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        acc_cnt[d] = 0;
      end else if (psel_d[d] && penable_d[d]) begin
        acc_cnt[d]++;
        if (pready_m[d]) begin
          exp_t e;
          bit   have;
          have = 1'b0;
          if (d == 0 && q0.size() > 0) begin
            e = q0.pop_front(); have = 1'b1;
          end else if (d == 1 && q1.size() > 0) begin
            e = q1.pop_front(); have = 1'b1;
          end
          if (!have) begin
            chk($sformatf("dut%0d_unexpected_pready", d), 32'(pready_m[d]), 32'd0);
          end else begin
            $display("dut%0d %s addr=%h prdata=%h pslverr=%0d cycles=%0d",
                     d, e.wr ? "WR" : "RD", paddr_d[d], prdata_m[d], pslverr_m[d], acc_cnt[d]);
            chk($sformatf("dut%0d_prdata", d),  prdata_m[d], e.rd);
            chk($sformatf("dut%0d_pslverr", d), 32'(pslverr_m[d]), 32'(e.err));
            chk($sformatf("dut%0d_cycles", d),  32'(acc_cnt[d]), 32'(e.cyc));
          end
          acc_cnt[d] = 0;
        end
      end else begin
        acc_cnt[d] = 0;
      end
    end
  end

  // One complete APB transfer; entered and left just after a rising edge,
  // so consecutive calls run back-to-back with no idle cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    int   n;
    e.wr  = wr;
    e.rd  = exp_rd;
    e.err = exp_err;
    e.cyc = (d == 0) ? WS0 + 1 : WS1 + 1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    psel_d[d]    = 1'b1;
    penable_d[d] = 1'b0;
    pwrite_d[d]  = wr;
    paddr_d[d]   = addr;
    pwdata_d[d]  = data;
    pstrb_d[d]   = strb;
    @(posedge clk);
    #1 penable_d[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready_m[d] && n < 20);
    if (!pready_m[d]) chk("pready_timeout", 32'(pready_m[d]), 32'd1);
    @(posedge clk);
    #1;
    psel_d[d]    = 1'b0;
    penable_d[d] = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel_d[d] = 1'b0; penable_d[d] = 1'b0; pwrite_d[d] = 1'b0;
      paddr_d[d] = '0; pwdata_d[d] = '0; pstrb_d[d] = '0;
      acc_cnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d_reset_prdata", d),  prdata_m[d], 32'd0);
      chk($sformatf("dut%0d_reset_pready", d),  32'(pready_m[d]), 32'd0);
      chk($sformatf("dut%0d_reset_pslverr", d), 32'(pslverr_m[d]), 32'd0);
    end
    @(posedge clk);
    #1;

    // Zero-wait-state slave: back-to-back write then read.
    xfer(1, 1'b1, 32'h4, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h4, 32'h0,         4'h0, 32'h1111_1111, 1'b0);

    // One-wait-state slave: clear the words the later checks rely on.
    xfer(0, 1'b1, 32'h8,  32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h14, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);

    // Full write, read back, then single-lane update.
    xfer(0, 1'b1, 32'h10,   32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0);
    xfer(0, 1'b0, 32'h10,   32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b1, 32'h10,   32'h0000_00AA, 4'h1, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b0, 32'h10,   32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);

    // Out-of-range read, misaligned write, memory untouched.
    xfer(0, 1'b0, 32'h1000, 32'h0,         4'h0, 32'h0,         1'b1);
    xfer(0, 1'b1, 32'h12,   32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1);
    xfer(0, 1'b0, 32'h10,   32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0);

    // Write with no strobes leaves the word alone and reports OKAY.
    xfer(0, 1'b1, 32'h14,   32'h1234_5678, 4'h0, 32'hDEAD_BEAA, 1'b0);
    xfer(0, 1'b0, 32'h14,   32'h0,         4'h0, 32'h0,         1'b0);

    // PENABLE asserted while idle must not start a transfer.
    psel_d[0] = 1'b1; penable_d[0] = 1'b1; pwrite_d[0] = 1'b0; paddr_d[0] = 32'h10;
    @(posedge clk);
    @(negedge clk);
    chk("idle_penable_pready", 32'(pready_m[0]), 32'd0);
    #1 psel_d[0] = 1'b0; penable_d[0] = 1'b0;
    @(posedge clk);
    #1;

    // Abort: psel drops during the wait cycle of a write.
    psel_d[0] = 1'b1; penable_d[0] = 1'b0; pwrite_d[0] = 1'b1;
    paddr_d[0] = 32'h8; pwdata_d[0] = 32'h55; pstrb_d[0] = 4'hF;
    @(posedge clk);
    #1 penable_d[0] = 1'b1;
    @(negedge clk);
    chk("abort_wait_pready", 32'(pready_m[0]), 32'd0);
    #1 psel_d[0] = 1'b0; penable_d[0] = 1'b0;
    @(negedge clk);
    chk("abort_after_pready", 32'(pready_m[0]), 32'd0);
    @(posedge clk);
    #1;
    xfer(0, 1'b0, 32'h8,  32'h0, 4'h0, 32'h0,         1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0);

    // Reset lands on the completion edge of a write to 0x20.
    psel_d[0] = 1'b1; penable_d[0] = 1'b0; pwrite_d[0] = 1'b1;
    paddr_d[0] = 32'h20; pwdata_d[0] = 32'hCAFE_F00D; pstrb_d[0] = 4'hF;
    @(posedge clk);
    #1 penable_d[0] = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_pready",  32'(pready_m[0]), 32'd0);
    chk("rst_mid_pslverr", 32'(pslverr_m[0]), 32'd0);
    chk("rst_mid_prdata",  prdata_m[0], 32'd0);
    psel_d[0] = 1'b0; penable_d[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
